// File: rtl/mul_acc_stream.sv
// -----------------------------------------------------------------------------
// mul_acc_stream
//   Streaming multiply-accumulate stage. Operand pairs arrive on a valid/ready
//   handshake and are summed as unsigned 64-bit products into an ACC_W-bit
//   accumulator. The beat flagged last closes the accumulation. Its total, its
//   beat count and a sticky overflow flag are then held on an output
//   handshake until the consumer takes them.
//
//   Pipeline: S1 operand regs -> Wallace multiplier -> S2 product reg ->
//             S3 accumulator -> output regs (HOLD)
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   clear         synchronous flush of pipeline, accumulator and counter
//   in_valid/in_ready, in_a, in_b, in_last   operand beat handshake
//   out_valid/out_ready                      result handshake
//   out_acc       accumulated sum of products (wraps modulo 2^ACC_W)
//   out_count     beats accumulated, saturating at all-ones
//   out_overflow  sticky carry-out of the accumulator
//
// Also contains wallacetree32x32, the 32x32 unsigned multiplier that S1 feeds.
// -----------------------------------------------------------------------------

// 32x32 unsigned multiplier. 32 partial products are reduced to two rows by
// levels of 3:2 carry-save compressors, and a single carry-propagate add
// follows. Row counts per level: 32-22-15-10-7-5-4-3-2.
module wallacetree32x32 (
  input  logic [31:0] a_i,  // multiplicand
  input  logic [31:0] b_i,  // multiplier
  output logic [63:0] p_o   // product
);

  logic [63:0] rows_s [0:32];
  logic [63:0] nxt_s  [0:32];
  int          n_s;
  int          m_s;

  // Partial-product generation followed by the carry-save reduction tree.
  always_comb begin
    for (int i = 0; i < 33; i++) begin
      rows_s[i] = 64'd0;
      nxt_s[i]  = 64'd0;
    end
    for (int i = 0; i < 32; i++) begin
      if (b_i[i]) begin
        rows_s[i] = 64'(a_i) << i;
      end else begin
        rows_s[i] = 64'd0;
      end
    end
    n_s = 32;
    m_s = 0;
    for (int lvl = 0; lvl < 8; lvl++) begin
      for (int k = 0; k < 33; k++) begin
        nxt_s[k] = 64'd0;
      end
      m_s = 0;
      for (int g = 0; g < 11; g++) begin
        if (3 * g + 2 < n_s) begin
          // Full adder per bit: sum stays in place, carry moves up one bit.
          // Bits shifted out above 63 do not matter because the product fits.
          nxt_s[m_s]     = rows_s[3*g] ^ rows_s[3*g+1] ^ rows_s[3*g+2];
          nxt_s[m_s + 1] = ((rows_s[3*g] & rows_s[3*g+1]) |
                            (rows_s[3*g] & rows_s[3*g+2]) |
                            (rows_s[3*g+1] & rows_s[3*g+2])) << 1;
          m_s = m_s + 2;
        end else begin
          // Rows that do not fill a whole group pass straight to the next level.
          if (3 * g < n_s) begin
            nxt_s[m_s] = rows_s[3*g];
            m_s = m_s + 1;
          end else begin
            m_s = m_s + 0;
          end
          if (3 * g + 1 < n_s) begin
            nxt_s[m_s] = rows_s[3*g+1];
            m_s = m_s + 1;
          end else begin
            m_s = m_s + 0;
          end
        end
      end
      for (int k = 0; k < 33; k++) begin
        rows_s[k] = nxt_s[k];
      end
      n_s = m_s;
    end
    p_o = rows_s[0] + rows_s[1];
  end

endmodule

module mul_acc_stream #(
  parameter int ACC_W = 72,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_overflow
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t             state_q,     state_d;
  logic               in_ready_q,  in_ready_d;
  logic               s1_valid_q,  s1_valid_d;
  logic               s1_last_q,   s1_last_d;
  logic [31:0]        a_q,         a_d;
  logic [31:0]        b_q,         b_d;
  logic               s2_valid_q,  s2_valid_d;
  logic               s2_last_q,   s2_last_d;
  logic [63:0]        prod_q,      prod_d;
  logic               s3_last_q,   s3_last_d;
  logic [ACC_W-1:0]   acc_q,       acc_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic               ovf_q,       ovf_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_acc_q,   out_acc_d;
  logic [CNT_W-1:0]   out_cnt_q,   out_cnt_d;
  logic               out_ovf_q,   out_ovf_d;

  logic [63:0]        prod_s;
  logic [ACC_W:0]     sum_s;
  logic               accept_s;

  wallacetree32x32 u_mul (
    .a_i (a_q),
    .b_i (b_q),
    .p_o (prod_s)
  );

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_acc      = out_acc_q;
  assign out_count    = out_cnt_q;
  assign out_overflow = out_ovf_q;

  // Next-state logic for the pipeline, the accumulator and the ACCUM/HOLD FSM.
  always_comb begin
    state_d     = state_q;
    s1_valid_d  = 1'b0;
    s1_last_d   = 1'b0;
    a_d         = a_q;
    b_d         = b_q;
    s2_valid_d  = 1'b0;
    s2_last_d   = 1'b0;
    prod_d      = prod_q;
    s3_last_d   = 1'b0;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    out_cnt_d   = out_cnt_q;
    out_ovf_d   = out_ovf_q;
    in_ready_d  = 1'b0;

    accept_s = in_valid && in_ready_q;
    // One extra bit catches the carry out of the top accumulator bit.
    sum_s    = {1'b0, acc_q} + (ACC_W + 1)'(prod_q);

    if (clear) begin
      // Flush wins over both handshakes, including a result being taken.
      state_d     = ACCUM;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
      out_acc_d   = '0;
      out_cnt_d   = '0;
      out_ovf_d   = 1'b0;
      in_ready_d  = 1'b1;
    end else begin
      // S1: capture operands on an accepted beat.
      if (accept_s) begin
        s1_valid_d = 1'b1;
        s1_last_d  = in_last;
        a_d        = in_a;
        b_d        = in_b;
      end else begin
        s1_valid_d = 1'b0;
        s1_last_d  = 1'b0;
      end

      // S2: register the product of the S1 operands.
      if (s1_valid_q) begin
        s2_valid_d = 1'b1;
        s2_last_d  = s1_last_q;
        prod_d     = prod_s;
      end else begin
        s2_valid_d = 1'b0;
        s2_last_d  = 1'b0;
      end

      // S3: accumulate, count with saturation, track sticky overflow.
      if (s2_valid_q) begin
        acc_d     = sum_s[ACC_W-1:0];
        ovf_d     = ovf_q | sum_s[ACC_W];
        s3_last_d = s2_last_q;
        if (cnt_q == {CNT_W{1'b1}}) begin
          cnt_d = cnt_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        s3_last_d = 1'b0;
      end

      case (state_q)
        ACCUM: begin
          // The last beat's product is in acc_q now; publish it.
          if (s3_last_q) begin
            state_d     = HOLD;
            out_valid_d = 1'b1;
            out_acc_d   = acc_q;
            out_cnt_d   = cnt_q;
            out_ovf_d   = ovf_q;
          end else begin
            state_d = ACCUM;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d     = ACCUM;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
            out_acc_d   = '0;
            out_cnt_d   = '0;
            out_ovf_d   = 1'b0;
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d     = ACCUM;
          out_valid_d = 1'b0;
        end
      endcase

      // Ready is registered: it is closed from the cycle after a last beat is
      // accepted until the cycle after its result is taken.
      in_ready_d = (state_d == ACCUM) && !s1_last_d && !s2_last_d && !s3_last_d;
    end
  end

  // State and pipeline registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      in_ready_q  <= 1'b1;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      prod_q      <= 64'd0;
      s3_last_q   <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_cnt_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      a_q         <= a_d;
      b_q         <= b_d;
      s2_valid_q  <= s2_valid_d;
      s2_last_q   <= s2_last_d;
      prod_q      <= prod_d;
      s3_last_q   <= s3_last_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_cnt_q   <= out_cnt_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_mul_acc_stream.sv
// Testbench for mul_acc_stream. Two instances share the stimulus: a default
// one (ACC_W=72, CNT_W=16) and a narrow one (ACC_W=64, CNT_W=4) that makes
// accumulator overflow and counter saturation reachable in short runs.
module tb_mul_acc_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_last;
  logic        out_ready;

  logic        rdy_a, vld_a, ovf_a;
  logic [71:0] acc_a;
  logic [15:0] cnt_a;
  logic        rdy_b, vld_b, ovf_b;
  logic [63:0] acc_b;
  logic [3:0]  cnt_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mul_acc_stream #(.ACC_W(72), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(rdy_a), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(vld_a), .out_ready(out_ready),
    .out_acc(acc_a), .out_count(cnt_a), .out_overflow(ovf_a)
  );

  mul_acc_stream #(.ACC_W(64), .CNT_W(4)) dut64 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(rdy_b), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(vld_b), .out_ready(out_ready),
    .out_acc(acc_b), .out_count(cnt_b), .out_overflow(ovf_b)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          last;
    logic [71:0] exp_acc;
    bit          exp_ovf;
    logic [63:0] exp_acc64;
    bit          exp_ovf64;
    int          exp_cnt;
    int          hold;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input bit last);
    int guard = 0;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    while (!(rdy_a && rdy_b) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!(rdy_a && rdy_b)) chk("in_ready timeout", 128'(rdy_a), 128'd1);
    @(posedge clk);
    #1;
    // Junk on the data lines while not valid must be ignored.
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_last = 1'($urandom);
  endtask

  // Wait for the result of a stream whose last beat was just accepted, check
  // latency and values, apply backpressure for 'hold' cycles, then take it.
  task automatic collect(input string nm, input logic [71:0] ea, input bit eoa,
                         input logic [63:0] eb, input bit eob, input int n, input int hold);
    int lat = 0;
    bit stable = 1'b1;
    int nb = (n > 15) ? 15 : n;
    int na = (n > 65535) ? 65535 : n;
    while (!vld_a && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, 128'(lat), 128'd4);
    chk({nm, " valid64"}, 128'(vld_b), 128'd1);
    chk({nm, " acc"}, 128'(acc_a), 128'(ea));
    chk({nm, " count"}, 128'(cnt_a), 128'(na));
    chk({nm, " ovf"}, 128'(ovf_a), 128'(eoa));
    chk({nm, " acc64"}, 128'(acc_b), 128'(eb));
    chk({nm, " count64"}, 128'(cnt_b), 128'(nb));
    chk({nm, " ovf64"}, 128'(ovf_b), 128'(eob));
    chk({nm, " in_ready in hold"}, 128'({rdy_a, rdy_b}), 128'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!(vld_a && vld_b && !rdy_a && !rdy_b && acc_a == ea && acc_b == eb &&
            cnt_a == 16'(na) && cnt_b == 4'(nb) && ovf_a == eoa && ovf_b == eob))
        stable = 1'b0;
    end
    chk({nm, " stable under backpressure"}, 128'(stable), 128'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({nm, " after take"}, 128'({rdy_a, rdy_b, vld_a, vld_b}), 128'b1100);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(3, 0))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [191:0] sum;
    int n;
    int guard;
    bit seen;

    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_a = 32'd0; in_b = 32'd0;
    in_last = 1'b0; out_ready = 1'b0;

    tbl[0] = '{32'd2, 32'd3, 1'b0, 72'd0, 1'b0, 64'd0, 1'b0, 0, 0};
    tbl[1] = '{32'd4, 32'd5, 1'b0, 72'd0, 1'b0, 64'd0, 1'b0, 0, 0};
    tbl[2] = '{32'd6, 32'd7, 1'b1, 72'd68, 1'b0, 64'd68, 1'b0, 3, 0};
    tbl[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 72'h00_FFFF_FFFE_0000_0001, 1'b0,
               64'hFFFF_FFFE_0000_0001, 1'b0, 1, 5};
    tbl[4] = '{32'd1, 32'd1, 1'b1, 72'd1, 1'b0, 64'd1, 1'b0, 1, 1};
    tbl[5] = '{32'd0, 32'd5, 1'b1, 72'd0, 1'b0, 64'd0, 1'b0, 1, 0};
    tbl[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 72'd0, 1'b0, 64'd0, 1'b0, 0, 0};
    tbl[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 72'h01_FFFF_FFFC_0000_0002, 1'b0,
               64'hFFFF_FFFC_0000_0002, 1'b1, 2, 2};

    // Reset state, while reset is held and after release.
    repeat (3) @(negedge clk);
    chk("reset state", 128'({rdy_a, vld_a, ovf_a, acc_a, cnt_a}), 128'({1'b1, 1'b0, 1'b0, 72'd0, 16'd0}));
    rst = 1'b0;
    @(negedge clk);
    chk("after reset release", 128'({rdy_b, vld_b, ovf_b, acc_b, cnt_b}), 128'({1'b1, 1'b0, 1'b0, 64'd0, 4'd0}));

    // Table-driven streams.
    for (int i = 0; i < 8; i++) begin
      send_beat(tbl[i].a, tbl[i].b, tbl[i].last);
      if (tbl[i].last)
        collect($sformatf("vec%0d", i), tbl[i].exp_acc, tbl[i].exp_ovf,
                tbl[i].exp_acc64, tbl[i].exp_ovf64, tbl[i].exp_cnt, tbl[i].hold);
    end

    // clear with two beats in flight: nothing may come out.
    send_beat(32'd5, 32'd5, 1'b0);
    send_beat(32'd6, 32'd6, 1'b1);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (vld_a || vld_b) seen = 1'b1;
    end
    chk("clear: no out_valid", 128'(seen), 128'd0);
    chk("clear: in_ready", 128'({rdy_a, rdy_b}), 128'b11);
    send_beat(32'd3, 32'd3, 1'b1);
    collect("after clear", 72'd9, 1'b0, 64'd9, 1'b0, 1, 0);

    // clear together with out_ready while holding a result: clear wins.
    send_beat(32'd2, 32'd2, 1'b1);
    guard = 0;
    while (!vld_a && guard < 20) begin @(negedge clk); guard++; end
    chk("pre-clear hold", 128'(vld_a), 128'd1);
    clear = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("clear in hold", 128'({vld_a, rdy_a, acc_a, cnt_a, ovf_a}), 128'({1'b0, 1'b1, 72'd0, 16'd0, 1'b0}));

    // Asynchronous reset while holding a result: outputs drop at once.
    send_beat(32'd7, 32'd7, 1'b0);
    send_beat(32'd8, 32'd8, 1'b1);
    guard = 0;
    while (!vld_a && guard < 20) begin @(negedge clk); guard++; end
    #2 rst = 1'b1;
    #1;
    chk("async reset outputs", 128'({vld_a, rdy_a, acc_a, cnt_a, ovf_a}), 128'({1'b0, 1'b1, 72'd0, 16'd0, 1'b0}));
    chk("async reset outputs64", 128'({vld_b, rdy_b, acc_b, cnt_b, ovf_b}), 128'({1'b0, 1'b1, 64'd0, 4'd0, 1'b0}));
    @(negedge clk) rst = 1'b0;

    // Reset mid-stream: the partial sum is dropped.
    send_beat(32'd9, 32'd9, 1'b0);
    send_beat(32'd10, 32'd10, 1'b0);
    #2 rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    send_beat(32'd2, 32'd3, 1'b0);
    send_beat(32'd4, 32'd4, 1'b1);
    collect("after reset", 72'd22, 1'b0, 64'd22, 1'b0, 2, 0);

    // Randomized streams against an arithmetic reference.
    for (int s = 0; s < 30; s++) begin
      logic [31:0] a;
      logic [31:0] b;
      n = (s == 5) ? 20 : $urandom_range(6, 1);
      sum = 192'd0;
      for (int k = 0; k < n; k++) begin
        a = pick();
        b = pick();
        sum = sum + 192'(64'(a) * 64'(b));
        if ($urandom_range(3, 0) == 0) repeat ($urandom_range(3, 1)) @(negedge clk);
        send_beat(a, b, k == n - 1);
      end
      collect($sformatf("rand%0d", s), sum[71:0], |sum[191:72], sum[63:0], |sum[191:64],
              n, $urandom_range(3, 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mul_acc_stream.md
Name: mul_acc_stream

Overview:
- Streaming multiply-accumulate stage that sits directly downstream of the 32x32 Wallace tree multiplier (wallacetree32x32) and consumes its 64-bit product.
- Accepts operand pairs over a valid/ready handshake and registers them into the combinational multiplier.
- Registers the product and accumulates it into a wide accumulator.
- On the beat flagged last, presents the total, the beat count and an overflow flag on an output handshake.

Parameters:
- ACC_W, 72, accumulator/result width in bits; legal range 64..128. Guard bits above 64 absorb carry growth.
- CNT_W, 16, beat counter width in bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous flush of the pipeline, accumulator and counter.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_a  input  32  unsigned multiplicand.
- in_b  input  32  unsigned multiplier.
- in_last  input  1  final beat of the current accumulation.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_acc  output  ACC_W  accumulated sum of products.
- out_count  output  CNT_W  number of beats accumulated; saturates at all-ones.
- out_overflow  output  1  sticky flag: the sum exceeded ACC_W bits.

Behaviour:
- Reset (async, active-high):
  - All pipeline valids, the accumulator, the counter and the overflow flag go to 0.
  - state=ACCUM, in_ready=1, out_valid=0, out_acc=0, out_count=0, out_overflow=0.
- Pipeline:
  - S1 registers a, b, last when in_valid&&in_ready.
  - The multiplier instance is driven from the S1 registers.
  - S2 registers the 64-bit product and last.
  - S3 zero-extends the product to ACC_W bits and adds it to the accumulator.
  - Throughput is one beat per cycle while in ACCUM.
- Latency: a last beat accepted at edge t gives out_valid=1 after edge t+3.
  - At that point out_acc includes that beat's product.
  - out_count includes that beat.
- State ACCUM:
  - in_ready = 1 unless a last beat is already in S1 or S2.
  - After a last beat is accepted, in_ready drops and stays low until the result is taken.
  - When the last beat is accumulated in S3, go to HOLD.
- State HOLD:
  - out_valid=1; out_acc, out_count and out_overflow are stable.
  - in_ready=0.
  - On out_valid&&out_ready: clear the accumulator, counter and overflow, then return to ACCUM.
  - in_ready=1 on the following cycle.
- Arithmetic:
  - Unsigned throughout.
  - If the carry out of bit ACC_W-1 is set on any add, set overflow (sticky). The accumulator wraps modulo 2^ACC_W.
  - The counter increments per accumulated beat and saturates at 2^CNT_W-1. It does not wrap.
- Simultaneous events:
  - clear has priority over every handshake. The next cycle state=ACCUM and all S1/S2 valids=0.
  - An in-flight product is discarded, the accumulator and counter are 0, and out_valid=0.
  - An out_ready handshake in the same cycle as clear is ignored.
- Zero operands: products of 0 still count as beats.
- A single beat with last=1 is a complete accumulation.
- Reset mid-operation: in-flight data is dropped with no spurious out_valid.
- in_a, in_b and in_last are ignored when in_valid=0.

Test Plan:
- Three beats (2,3), (4,5), (6,7 last) on consecutive cycles:
  - out_valid exactly 3 cycles after the last accept.
  - out_acc=68, out_count=3, out_overflow=0.
- Single beat (0xFFFFFFFF, 0xFFFFFFFF, last), ACC_W=72:
  - out_acc=0x00FFFFFFFE00000001, out_count=1.
- ACC_W=64, two beats of (0xFFFFFFFF, 0xFFFFFFFF), last on the second:
  - out_acc=0xFFFFFFFC00000002, out_overflow=1.
- Backpressure: out_ready held low 5 cycles after out_valid:
  - Outputs stay stable and in_ready=0 throughout.
  - After the handshake, in_ready=1 on the next cycle.
  - A new stream (1,1, last) gives out_acc=1, out_count=1, out_overflow=0.
- clear asserted while two beats are in flight:
  - No out_valid.
  - Subsequent (3,3, last) gives out_acc=9, out_count=1.
- rst asserted asynchronously mid-stream:
  - All outputs go to 0 immediately and in_ready=1.
  - A fresh stream after release accumulates correctly.
